// File: rtl/select_k_from_n_alloc_pkg.sv
// Shared types and helpers for the select-K-from-N round-robin allocator.
// Widths are bounded by MAX_W candidates and MAX_ID_W id bits.
package select_k_pkg;

  localparam int MAX_W    = 64;
  localparam int MAX_ID_W = 6;

  function automatic int id_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } slot_t;

  // Bit at position amt moves to bit 0; only the low w bits participate.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] v,
                                            input int amt, input int w);
    logic [MAX_W-1:0] r;
    int               src;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        src = i + amt;
        if (src >= w) src = src - w;
        r[i] = v[src];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int amt, input int w);
    logic [MAX_W-1:0] r;
    int               dst;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        dst = i + amt;
        if (dst >= w) dst = dst - w;
        r[dst] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/select_k_from_n_alloc_rr_pick.sv
// Combinational K-stage round-robin picker: rotate by ptr, successive
// priority-and-clear per requesting slot, then map positions back to ids.
module select_k_rr_pick
  import select_k_pkg::*;
#(
  parameter int SEL_WIDTH = 8,
  parameter int GRANT_NUM = 2,
  parameter int ID_W      = 3
) (
  input  logic [SEL_WIDTH-1:0]           cand_i,
  input  logic [ID_W-1:0]                ptr_i,
  input  logic [GRANT_NUM-1:0]           req_i,
  output logic [GRANT_NUM-1:0]           hit_o,
  output logic [GRANT_NUM*ID_W-1:0]      id_o,
  output logic [GRANT_NUM*SEL_WIDTH-1:0] oh_o,
  output logic [ID_W-1:0]                ptr_nxt_o
);

  logic [MAX_W-1:0] remain;
  logic             found;
  int               pos;
  int               idx;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    remain    = rotr(MAX_W'(cand_i), int'(ptr_i), SEL_WIDTH);
    hit_o     = '0;
    id_o      = '0;
    oh_o      = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    pos       = 0;
    idx       = 0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      found = 1'b0;
      pos   = 0;
      if (req_i[k]) begin
        for (int i = 0; i < MAX_W; i++) begin
          if (!found && remain[i]) begin
            found = 1'b1;
            pos   = i;
          end
        end
      end
      if (found) begin
        remain[pos] = 1'b0;
        // Un-rotate: rotated position back to absolute id.
        idx = pos + int'(ptr_i);
        if (idx >= SEL_WIDTH) idx = idx - SEL_WIDTH;
        hit_o[k]                  = 1'b1;
        id_o[k*ID_W +: ID_W]      = ID_W'(idx);
        oh_o[k*SEL_WIDTH + idx]   = 1'b1;
        ptr_nxt_o = (idx == SEL_WIDTH - 1) ? '0 : ID_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/select_k_from_n_alloc.sv
// Registered round-robin K-way allocator with per-slot valid/ack handshakes.
// Optional macro SELK_REVALIDATE_EN drops held grants whose sel_i bit clears.
module select_k_from_n_alloc
  import select_k_pkg::*;
#(
  parameter  int SEL_WIDTH = 8,
  parameter  int GRANT_NUM = 2,
  localparam int ID_W      = id_width(SEL_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  input  logic [GRANT_NUM-1:0]           req_vld_i,
  input  logic [GRANT_NUM-1:0]           grant_ack_i,
  input  logic                           flush_i,
  output logic [GRANT_NUM-1:0]           grant_vld_o,
  output logic [GRANT_NUM*ID_W-1:0]      grant_id_o,
  output logic [GRANT_NUM*SEL_WIDTH-1:0] grant_oh_o
);

  slot_t                               slot_q [GRANT_NUM];
  slot_t                               slot_d [GRANT_NUM];
  logic [GRANT_NUM-1:0][SEL_WIDTH-1:0] oh_q, oh_d;
  logic [ID_W-1:0]                     ptr_q, ptr_d;

  logic [GRANT_NUM-1:0]           vld_vec, drop, free, pick_req, pick_hit;
  logic [SEL_WIDTH-1:0]           excluded, cand;
  logic [GRANT_NUM*ID_W-1:0]      pick_id;
  logic [GRANT_NUM*SEL_WIDTH-1:0] pick_oh;
  logic [ID_W-1:0]                pick_ptr;

  always_comb begin
    excluded = '0;
    drop     = '0;
    vld_vec  = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      vld_vec[k] = slot_q[k].vld;
      // Acked slots still exclude their id: sel_i lags the ack by a cycle.
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (slot_q[k].vld && (slot_q[k].id == MAX_ID_W'(i))) excluded[i] = 1'b1;
      end
    end
`ifdef SELK_REVALIDATE_EN
    for (int k = 0; k < GRANT_NUM; k++) begin
      drop[k] = slot_q[k].vld & ~(|(oh_q[k] & sel_i));
    end
`endif
    free     = ~vld_vec | grant_ack_i | drop;
    pick_req = flush_i ? '0 : (free & req_vld_i);
    cand     = sel_i & ~excluded;
  end

  select_k_rr_pick #(
    .SEL_WIDTH (SEL_WIDTH),
    .GRANT_NUM (GRANT_NUM),
    .ID_W      (ID_W)
  ) u_pick (
    .cand_i    (cand),
    .ptr_i     (ptr_q),
    .req_i     (pick_req),
    .hit_o     (pick_hit),
    .id_o      (pick_id),
    .oh_o      (pick_oh),
    .ptr_nxt_o (pick_ptr)
  );

  always_comb begin
    for (int k = 0; k < GRANT_NUM; k++) begin
      slot_d[k] = slot_q[k];
      oh_d[k]   = oh_q[k];
      if (flush_i) begin
        slot_d[k] = '0;
        oh_d[k]   = '0;
      end else if (free[k]) begin
        slot_d[k].vld = pick_hit[k];
        slot_d[k].id  = pick_hit[k] ? MAX_ID_W'(pick_id[k*ID_W +: ID_W]) : '0;
        oh_d[k]       = pick_oh[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
    ptr_d = flush_i ? ptr_q : pick_ptr;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the slot array is a handful of control flops, so it is reset explicitly; outputs must read 0 in reset.
      for (int k = 0; k < GRANT_NUM; k++) slot_q[k] <= '0;
      oh_q  <= '0;
      ptr_q <= '0;
    end else begin
      for (int k = 0; k < GRANT_NUM; k++) slot_q[k] <= slot_d[k];
      oh_q  <= oh_d;
      ptr_q <= ptr_d;
    end
  end

  assign grant_oh_o = oh_q;

  for (genvar k = 0; k < GRANT_NUM; k++) begin : g_out
    assign grant_vld_o[k]             = slot_q[k].vld;
    assign grant_id_o[k*ID_W +: ID_W] = slot_q[k].id[ID_W-1:0];
  end

endmodule
